stopwatch_sequencer: RTL

//  Control FSM for the lab stopwatch datapath: BCD counter chain, lap latch, display.

---
 rtl/stopwatch_sequencer_pkg.sv | 33 +++
 rtl/stopwatch_sequencer_button_conditioner.sv | 60 ++++++
 rtl/stopwatch_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/stopwatch_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_sequencer_pkg
// Shared definitions for the lab stopwatch control block and the display
// block: FSM state encodings, default timing constants and small helpers.
// No ports (package).
// ---------------------------------------------------------------------------
package stopwatch_sequencer_pkg;

  // Encodings 5..7 are unused; the FSM steers them back to ST_CLEAR.
  typedef enum logic [2:0] {
    ST_CLEAR   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_RUN     = 3'd2,
    ST_LAP     = 3'd3,
    ST_STOPPED = 3'd4
  } state_t;

  // 20 ms debounce lockout and 100 Hz count tick at a 50 MHz qzt_clk.
  localparam int DEFAULT_DEBOUNCE_CYCLES  = 1000000;
  localparam int DEFAULT_TICK_DIV         = 500000;
  localparam bit DEFAULT_STOP_ON_OVERFLOW = 1'b1;

  // States in which the counter chain advances.
  function automatic logic is_counting(input state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

  // Bits needed to hold the values 0 .. n-1 (at least one bit).
  function automatic int counter_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stopwatch_sequencer_button_conditioner.sv
// ---------------------------------------------------------------------------
// stopwatch_sequencer_button_conditioner
// Turns one raw, asynchronous push-button pin into a single-cycle press
// pulse: 2-FF synchroniser, rising-edge detect, and a lockout counter that
// drops every further edge for DEBOUNCE_CYCLES cycles after an accepted one.
// Ports:
//   qzt_clk  in  system clock
//   reset    in  asynchronous active-high reset
//   pin      in  raw button level, asynchronous to qzt_clk
//   press    out registered 1-cycle pulse per accepted press
// ---------------------------------------------------------------------------
module stopwatch_sequencer_button_conditioner
  import stopwatch_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic qzt_clk,
  input  logic reset,
  input  logic pin,
  output logic press
);

  localparam int LW = counter_width(DEBOUNCE_CYCLES);
  localparam logic [LW-1:0] LOCKOUT_LOAD = LW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;   // previous synchronised level, for edge detect
  logic [LW-1:0] lockout_reg;
  logic          press_reg;
  logic          rise;

  assign rise = sync2_reg & ~level_reg;

  // The accepting cycle itself counts as the first lockout cycle, hence the
  // load of DEBOUNCE_CYCLES-1.
  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      level_reg   <= 1'b0;
      lockout_reg <= '0;
      press_reg   <= 1'b0;
    end else begin
      sync1_reg <= pin;
      sync2_reg <= sync1_reg;
      level_reg <= sync2_reg;
      press_reg <= 1'b0;
      if (rise && (lockout_reg == '0)) begin
        press_reg   <= 1'b1;
        lockout_reg <= LOCKOUT_LOAD;
      end else if (lockout_reg != '0) begin
        lockout_reg <= lockout_reg - LW'(1);
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/stopwatch_sequencer.sv
// ---------------------------------------------------------------------------
// stopwatch_sequencer
// Control FSM for the lab stopwatch datapath (BCD counter chain, lap latch,
// display). Conditions both buttons, generates the gated count tick from
// qzt_clk, drives the counter-chain clear and the lap-latch hold, and
// watches the top-stage carry for overflow. Holds no time digits.
// Ports:
//   qzt_clk         in   system clock, the only clock
//   reset           in   asynchronous active-high reset
//   btn_start_stop  in   raw push-button (asynchronous)
//   btn_lap_clear   in   raw push-button (asynchronous)
//   top_carry       in   carry out of the most-significant counter stage
//   count_tick      out  1-cycle pulse advancing the counter chain
//   counter_reset   out  1-cycle synchronous clear to the counter chain
//   hold_flag       out  1 = lap latch frozen
//   running         out  1 in RUN and LAP
//   overflow        out  sticky overflow indicator, cleared in CLEAR
// All outputs are registered; each is computed from the next state so it
// changes on the same edge as the FSM.
// ---------------------------------------------------------------------------
module stopwatch_sequencer
  import stopwatch_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = DEFAULT_DEBOUNCE_CYCLES,
  parameter int TICK_DIV         = DEFAULT_TICK_DIV,
  parameter bit STOP_ON_OVERFLOW = DEFAULT_STOP_ON_OVERFLOW
) (
  input  logic qzt_clk,
  input  logic reset,
  input  logic btn_start_stop,
  input  logic btn_lap_clear,
  input  logic top_carry,
  output logic count_tick,
  output logic counter_reset,
  output logic hold_flag,
  output logic running,
  output logic overflow
);

  localparam int PW = counter_width(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  state_t        state_reg, state_next;
  logic [PW-1:0] prescaler_reg, prescaler_next;
  logic          overflow_reg, overflow_next;
  logic          count_tick_reg, count_tick_next;
  logic          counter_reset_reg;
  logic          hold_flag_reg;
  logic          running_reg;
  logic          carry_prev_reg;
  logic          carry_rise;
  logic          ss_press;
  logic          lc_press;

  stopwatch_sequencer_button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_start_stop (
    .qzt_clk (qzt_clk),
    .reset   (reset),
    .pin     (btn_start_stop),
    .press   (ss_press)
  );

  stopwatch_sequencer_button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_lap_clear (
    .qzt_clk (qzt_clk),
    .reset   (reset),
    .pin     (btn_lap_clear),
    .press   (lc_press)
  );

  // top_carry comes from the counter chain in this clock domain, so a single
  // registered compare is enough.
  assign carry_rise = top_carry & ~carry_prev_reg;

  always_comb begin
    state_next      = state_reg;
    overflow_next   = overflow_reg;
    prescaler_next  = prescaler_reg;
    count_tick_next = 1'b0;

    // start_stop is tested first everywhere, so a same-cycle lap_clear press
    // is simply dropped.
    case (state_reg)
      ST_CLEAR:   state_next = ST_IDLE;
      ST_IDLE:    if (ss_press) state_next = ST_RUN;
      ST_RUN:     if (ss_press) state_next = ST_STOPPED;
                  else if (lc_press) state_next = ST_LAP;
      ST_LAP:     if (ss_press) state_next = ST_STOPPED;
                  else if (lc_press) state_next = ST_RUN;
      ST_STOPPED: if (ss_press) state_next = ST_RUN;
                  else if (lc_press) state_next = ST_CLEAR;
      default:    state_next = ST_CLEAR;
    endcase

    // Overflow overrides any button decision made above.
    if (is_counting(state_reg) && carry_rise) begin
      overflow_next = 1'b1;
      if (STOP_ON_OVERFLOW) begin
        state_next = ST_STOPPED;
      end
    end

    // The prescaler only advances in cycles that stay inside RUN/LAP, so no
    // tick is ever emitted on the edge that leaves RUN/LAP, and the entry
    // edge does not advance it either. A stopped prescaler keeps its phase.
    if ((state_reg == ST_CLEAR) || (state_next == ST_CLEAR)) begin
      prescaler_next = '0;
      overflow_next  = 1'b0;
    end else if (is_counting(state_reg) && is_counting(state_next)) begin
      if (prescaler_reg == TICK_LAST) begin
        prescaler_next  = '0;
        count_tick_next = 1'b1;
      end else begin
        prescaler_next = prescaler_reg + PW'(1);
      end
    end
  end

  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      state_reg         <= ST_CLEAR;
      prescaler_reg     <= '0;
      overflow_reg      <= 1'b0;
      count_tick_reg    <= 1'b0;
      counter_reset_reg <= 1'b1;
      hold_flag_reg     <= 1'b0;
      running_reg       <= 1'b0;
      carry_prev_reg    <= 1'b0;
    end else begin
      state_reg         <= state_next;
      prescaler_reg     <= prescaler_next;
      overflow_reg      <= overflow_next;
      count_tick_reg    <= count_tick_next;
      counter_reset_reg <= (state_next == ST_CLEAR);
      hold_flag_reg     <= (state_next == ST_LAP);
      running_reg       <= is_counting(state_next);
      carry_prev_reg    <= top_carry;
    end
  end

  assign count_tick    = count_tick_reg;
  assign counter_reset = counter_reset_reg;
  assign hold_flag     = hold_flag_reg;
  assign running       = running_reg;
  assign overflow      = overflow_reg;

endmodule
